snake_game_ctrl: RTL and testbench
==================================

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter INIT_PERIOD, default 8, meaning frames per snake step at game start.
REQ-002 SHALL have parameter MIN_PERIOD, default 2, meaning the floor on frames per step.
REQ-003 SHALL have parameter SCORE_W, default 8, meaning score counter width.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port frame_start, input, 1, one-cycle pulse at the start of each video frame.
REQ-007 SHALL have ports up, down, left, right, input, 1 each, raw asynchronous buttons.
REQ-008 SHALL have port move_done, input, 1, datapath pulse: step finished, collision/food_eaten valid.
REQ-009 SHALL have ports collision and food_eaten, input, 1 each, sampled only with move_done.
REQ-010 SHALL have port move_tick, output, 1, one-cycle pulse commanding one snake step.
REQ-011 SHALL have port dir, output, 2, committed direction: 00 up, 01 down, 10 left, 11 right.
REQ-012 SHALL have port grow, output, 1, one-cycle pulse telling the datapath to extend the snake.
REQ-013 SHALL have port clear_req, output, 1, one-cycle pulse to reinitialise snake/food.
REQ-014 SHALL have port game_state, output, 2: 00 IDLE, 01 PLAY, 10 WAIT, 11 OVER.
REQ-015 SHALL have port score, output, SCORE_W, food count this game.

Function
REQ-016 Buttons SHALL pass a 2-flop synchroniser, then a rising-edge detector; edge = synchronised high, previous low.
REQ-017 IDLE: on any button edge SHALL pulse clear_req one cycle, zero score, load period = INIT_PERIOD, clear frame counter, go PLAY.
REQ-018 Pending direction SHALL update on button edge (priority up>down>left>right), except reversal of committed dir is ignored.
REQ-019 PLAY: each frame_start increments frame counter; when counter = period-1 and frame_start, SHALL pulse move_tick, commit dir<=pending, clear counter, go WAIT.
REQ-020 move_tick and dir update SHALL occur in the same cycle; dir stable until next move_tick.
REQ-021 WAIT: frame_start pulses SHALL be ignored (counter held at 0); on move_done with collision=1 go OVER.
REQ-022 WAIT: on move_done, collision=0, food_eaten=1: grow pulse same cycle as transition, score +1 saturating at all-ones, go PLAY.
REQ-023 WAIT: on move_done, both 0: go PLAY without grow.
REQ-024 collision and food_eaten both 1 SHALL be treated as collision; no grow, no score change.
REQ-025 Period SHALL decrement by 1 when new score is a nonzero multiple of 4, never below MIN_PERIOD.
REQ-026 OVER: outputs frozen (score held); on button edge go IDLE; clear_req not issued until the following IDLE->PLAY.
REQ-027 move_done outside WAIT SHALL be ignored.
REQ-028 A button edge in the same cycle as move_tick SHALL update pending against the newly committed dir.

Reset
REQ-029 reset asserted SHALL immediately force: state IDLE, dir 11, pending 11, score 0, period INIT_PERIOD, counter 0, all pulses 0, synchroniser/edge flops 0.
REQ-030 reset mid-game (any state) SHALL abort with no further move_tick, grow or clear_req pulse.

Structure
REQ-031 State encoding, direction encoding, and INIT_PERIOD/MIN_PERIOD defaults SHALL live in shared package snake_pkg.
REQ-032 Synchroniser plus edge detector SHALL be sub-module btn_sync_edge, instantiated once per button.
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 Reset, press right -> clear_req one pulse, state PLAY; 8 frame_start later -> move_tick, dir=11.
REQ-035 In PLAY, dir=11, press left -> ignored, next move_tick dir=11; press up -> next move_tick dir=00.
REQ-036 Four food steps (move_done+food_eaten) -> four grow pulses, score=4, step interval 7 frames.
REQ-037 move_done with collision=1 and food_eaten=1 -> OVER, score unchanged, no grow; later frames no move_tick.
REQ-038 frame_start pulses during WAIT -> no move_tick, counter 0; then move_done -> next tick after full period.
REQ-039 reset asserted in WAIT mid-step -> immediately IDLE, score 0, dir 11, no pulses until a new button edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings and defaults for the snake game controller.
// Holds state/direction enums, period defaults and the reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WAIT = 2'b10,
    ST_OVER = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam int INIT_PERIOD_DEF = 8;
  localparam int MIN_PERIOD_DEF  = 2;

  // up<->down and left<->right differ only in bit 0
  function automatic dir_e dir_opposite(dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for one raw button.
// Ports: clk, rst (async high), btn_i raw button, rise_o one-cycle edge.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control FSM: button handling, step pacing, score and speed.
// Ports: clk, reset, frame_start, up/down/left/right, move_done, collision,
// food_eaten in; move_tick, dir, grow, clear_req, game_state, score out.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int INIT_PERIOD = INIT_PERIOD_DEF,
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               move_done,
  input  logic               collision,
  input  logic               food_eaten,
  output logic               move_tick,
  output logic [1:0]         dir,
  output logic               grow,
  output logic               clear_req,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] score
);

  localparam int PW = $clog2(INIT_PERIOD + 1);

  logic [3:0] raw;
  logic [3:0] rise;
  logic       any_rise;

  assign raw      = {right, left, down, up};
  assign any_rise = |rise;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_sync_edge u_btn (
      .clk    (clk),
      .rst    (reset),
      .btn_i  (raw[i]),
      .rise_o (rise[i])
    );
  end

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  dir_e               pend_q, pend_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [PW-1:0]      per_q, per_d;
  logic [PW-1:0]      cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               grow_q, grow_d;
  logic               clr_q, clr_d;

  logic [SCORE_W-1:0] score_inc;
  dir_e               ref_dir;
  dir_e               cand;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_RIGHT;
      pend_q  <= DIR_RIGHT;
      score_q <= '0;
      per_q   <= PW'(INIT_PERIOD);
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      grow_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      score_q <= score_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      grow_q  <= grow_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    score_d   = score_q;
    per_d     = per_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    grow_d    = 1'b0;
    clr_d     = 1'b0;
    ref_dir   = dir_q;
    cand      = DIR_RIGHT;
    score_inc = (score_q == '1) ? score_q
                                : score_q + SCORE_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (any_rise) begin
          clr_d   = 1'b1;
          score_d = '0;
          per_d   = PW'(INIT_PERIOD);
          cnt_d   = '0;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (frame_start) begin
          if (cnt_q == per_q - PW'(1)) begin
            tick_d  = 1'b1;
            dir_d   = pend_q;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = '0;
        if (move_done) begin
          state_d = collision ? ST_OVER : ST_PLAY;
          if (!collision && food_eaten) begin
            grow_d  = 1'b1;
            score_d = score_inc;
            // speed up every fourth food, floored
            if (score_inc[1:0] == 2'b00 &&
                score_inc != '0 &&
                per_q > PW'(MIN_PERIOD))
              per_d = per_q - PW'(1);
          end
        end
      end
      ST_OVER: begin
        if (any_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // a press coinciding with a commit is judged
    // against the direction being committed
    if (tick_d) ref_dir = pend_q;

    priority case (1'b1)
      rise[0]: cand = DIR_UP;
      rise[1]: cand = DIR_DOWN;
      rise[2]: cand = DIR_LEFT;
      default: cand = DIR_RIGHT;
    endcase

    if (any_rise && state_q != ST_OVER &&
        cand != dir_opposite(ref_dir))
      pend_d = cand;
  end

  assign move_tick  = tick_q;
  assign dir        = dir_q;
  assign grow       = grow_q;
  assign clear_req  = clr_q;
  assign game_state = state_q;
  assign score      = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl.
// Directed stimulus pushes expected pulses; a monitor pops and compares.
module tb_snake_game_ctrl;

  typedef struct {
    logic [2:0] ev;
    logic [1:0] dir;
    logic [7:0] score;
    logic [1:0] st;
    int         frame;
  } exp_t;

  localparam logic [2:0] EV_TICK = 3'b001;
  localparam logic [2:0] EV_GROW = 3'b010;
  localparam logic [2:0] EV_CLR  = 3'b100;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic [3:0] btn;
  logic       move_done;
  logic       collision;
  logic       food_eaten;
  logic       move_tick;
  logic [1:0] dir;
  logic       grow;
  logic       clear_req;
  logic [1:0] game_state;
  logic [7:0] score;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   frames = 0;

  always #5 clk = ~clk;

  snake_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .up          (btn[0]),
    .down        (btn[1]),
    .left        (btn[2]),
    .right       (btn[3]),
    .move_done   (move_done),
    .collision   (collision),
    .food_eaten  (food_eaten),
    .move_tick   (move_tick),
    .dir         (dir),
    .grow        (grow),
    .clear_req   (clear_req),
    .game_state  (game_state),
    .score       (score)
  );

  always @(negedge clk) begin
    logic [2:0] ev;
    exp_t e;
    ev = {clear_req, grow, move_tick};
    if (!reset && ev != 3'b000) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event got ev=%b dir=%0d score=%0d st=%0d frame=%0d, none required",
                 ev, dir, score, game_state, frames);
      end else begin
        e = q.pop_front();
        if (ev != e.ev || dir != e.dir || score != e.score ||
            game_state != e.st ||
            (e.frame >= 0 && frames != e.frame)) begin
          fails++;
          $display("FAIL event got ev=%b dir=%0d score=%0d st=%0d frame=%0d, required ev=%b dir=%0d score=%0d st=%0d frame=%0d",
                   ev, dir, score, game_state, frames,
                   e.ev, e.dir, e.score, e.st, e.frame);
        end
      end
    end
  end

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic [2:0] ev, logic [1:0] d,
                      logic [7:0] s, logic [1:0] st, int f);
    exp_t e;
    e.ev = ev; e.dir = d; e.score = s; e.st = st; e.frame = f;
    q.push_back(e);
  endtask

  task automatic press(int b);
    btn[b] = 1'b1;
    cyc(4);
    btn[b] = 1'b0;
    cyc(4);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    frames++;
    cyc(1);
    frame_start = 1'b0;
    cyc(2);
  endtask

  task automatic mdone(logic c, logic f);
    move_done = 1'b1;
    collision = c;
    food_eaten = f;
    cyc(1);
    move_done = 1'b0;
    collision = 1'b0;
    food_eaten = 1'b0;
    cyc(2);
  endtask

  task automatic run_period(int n, logic [1:0] d, logic [7:0] s);
    push(EV_TICK, d, s, 2'b10, frames + n);
    repeat (n) frame();
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    btn = 4'b0;
    move_done = 1'b0;
    collision = 1'b0;
    food_eaten = 1'b0;
    cyc(3);
    chk("rst_state", game_state, 0);
    chk("rst_dir", dir, 3);
    chk("rst_score", score, 0);
    chk("rst_pulses", {clear_req, grow, move_tick}, 0);
    reset = 1'b0;
    cyc(2);

    // start game with right
    push(EV_CLR, 2'd3, 8'd0, 2'b01, -1);
    press(3);
    chk("start_state", game_state, 1);
    run_period(8, 2'd3, 8'd0);
    chk("wait_state", game_state, 2);
    mdone(1'b0, 1'b0);
    chk("play_again", game_state, 1);
    // move_done outside WAIT does nothing
    mdone(1'b0, 1'b1);
    chk("md_in_play_score", score, 0);
    chk("md_in_play_state", game_state, 1);

    // reversal ignored, then turn up
    press(2);
    run_period(8, 2'd3, 8'd0);
    mdone(1'b0, 1'b0);
    press(0);
    run_period(8, 2'd0, 8'd0);
    mdone(1'b0, 1'b0);

    // four foods, speed-up after the fourth
    for (int k = 1; k <= 4; k++) begin
      run_period(8, 2'd0, 8'(k - 1));
      push(EV_GROW, 2'd0, 8'(k), 2'b01, -1);
      mdone(1'b0, 1'b1);
    end
    chk("score4", score, 4);
    run_period(7, 2'd0, 8'd4);

    // frames during WAIT are ignored
    repeat (3) frame();
    chk("wait_hold", game_state, 2);
    mdone(1'b0, 1'b0);
    run_period(7, 2'd0, 8'd4);
    mdone(1'b0, 1'b0);

    // press right, then left edge lands on the commit cycle
    press(3);
    push(EV_TICK, 2'd3, 8'd4, 2'b10, frames + 7);
    repeat (6) frame();
    btn[2] = 1'b1;
    cyc(2);
    frame_start = 1'b1;
    frames++;
    cyc(1);
    frame_start = 1'b0;
    cyc(3);
    btn[2] = 1'b0;
    cyc(4);
    mdone(1'b0, 1'b0);
    run_period(7, 2'd3, 8'd4);

    // collision with food -> over, no grow
    mdone(1'b1, 1'b1);
    chk("over_state", game_state, 3);
    chk("over_score", score, 4);
    repeat (10) frame();
    mdone(1'b0, 1'b1);
    chk("over_frozen_score", score, 4);
    chk("over_frozen_state", game_state, 3);

    // over -> idle, no clear yet
    press(0);
    chk("idle_state", game_state, 0);
    chk("idle_score_held", score, 4);

    // new game, period restored
    push(EV_CLR, 2'd3, 8'd0, 2'b01, -1);
    press(1);
    chk("new_score", score, 0);
    run_period(8, 2'd1, 8'd0);
    push(EV_GROW, 2'd1, 8'd1, 2'b01, -1);
    mdone(1'b0, 1'b1);
    run_period(8, 2'd1, 8'd1);
    repeat (2) frame();

    // async reset in WAIT
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_state", game_state, 0);
    chk("arst_score", score, 0);
    chk("arst_dir", dir, 3);
    chk("arst_pulses", {clear_req, grow, move_tick}, 0);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    repeat (10) frame();
    mdone(1'b0, 1'b1);
    chk("post_rst_state", game_state, 0);
    chk("post_rst_score", score, 0);
    cyc(3);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
